// File: rtl/serializador_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serializador_pkg
//  Purpose  : Shared types, constants and helpers for the fila drain serializer.
//  Revision : 1.0  initial release
// ============================================================================
package serializador_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DATA_BITS = 8;

    // Even parity makes the total count of ones (data + parity) even.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serializador_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : serializador_bit_timer
//  Purpose  : Free-running 0..BIT_CYCLES-1 counter; bit_tick_o marks the last
//             cycle of each serial bit.
//  Revision : 1.0  initial release
// ============================================================================
module serializador_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk_10KHz,
    input  logic reset,
    input  logic clear_i,
    output logic bit_tick_o
);

    localparam int                 c_CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BIT_CYCLES - 1);

    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear_i || (count_q == c_LAST)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bit_tick_o = (count_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/serializador.sv
`default_nettype none
// ============================================================================
//  Module   : serializador
//  Purpose  : Pops bytes from the fila head and sends them as framed serial
//             data: start bit, LSB-first data, optional parity, stop bit(s).
//  Revision : 1.0  initial release
// ============================================================================
module serializador
    import serializador_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BITS,
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk_10KHz,
    input  logic                  reset,
    input  logic                  enable_in,
    input  logic [7:0]            len_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  dequeue_out,
    output logic                  serial_out,
    output logic                  busy_out,
    output logic                  frame_done_out,
    output logic [7:0]            sent_count_out
);

    localparam int                   c_IDX_W      = $clog2(DATA_WIDTH);
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX   = c_IDX_W'(DATA_WIDTH - 1);
    localparam int                   c_STOP_TOTAL = STOP_BITS * BIT_CYCLES;
    localparam int                   c_STOP_W     = $clog2(c_STOP_TOTAL + 1);
    localparam logic [c_STOP_W-1:0]  c_STOP_LOAD  = c_STOP_W'(c_STOP_TOTAL - 1);
    localparam logic [c_STOP_W-1:0]  c_STOP_ONE   = c_STOP_W'(1);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic                  parity_q;
    logic [c_IDX_W-1:0]    bit_idx_q;
    logic [c_STOP_W-1:0]   stop_left_q;

    logic w_bit_tick;
    logic w_timer_clear;
    logic w_to_stop;

    // Timer is held at zero while idle so the start bit gets a full bit period.
    assign w_timer_clear = (state_q == IDLE);

    assign w_to_stop = w_bit_tick &&
                       (((state_q == DATA) && (bit_idx_q == c_LAST_IDX) && (PARITY_EN == 0)) ||
                        (state_q == PARITY));

    serializador_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk_10KHz  (clk_10KHz),
        .reset      (reset),
        .clear_i    (w_timer_clear),
        .bit_tick_o (w_bit_tick)
    );

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            parity_q       <= 1'b0;
            bit_idx_q      <= '0;
            stop_left_q    <= '0;
            serial_out     <= 1'b1;
            dequeue_out    <= 1'b0;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
            sent_count_out <= 8'd0;
        end else begin
            dequeue_out    <= 1'b0;
            frame_done_out <= 1'b0;

            case (state_q)
                IDLE: begin
                    serial_out <= 1'b1;
                    busy_out   <= 1'b0;
                    if (enable_in && (len_in != 8'd0)) begin
                        shreg_q     <= data_in;
                        parity_q    <= calc_parity(data_in, PARITY_ODD != 0);
                        dequeue_out <= 1'b1;
                        serial_out  <= 1'b0;
                        busy_out    <= 1'b1;
                        state_q     <= START;
                    end
                end

                START: begin
                    if (w_bit_tick) begin
                        serial_out <= shreg_q[0];
                        shreg_q    <= shreg_q >> 1;
                        bit_idx_q  <= '0;
                        state_q    <= DATA;
                    end
                end

                DATA: begin
                    if (w_bit_tick) begin
                        if (bit_idx_q == c_LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                serial_out <= parity_q;
                                state_q    <= PARITY;
                            end
                        end else begin
                            serial_out <= shreg_q[0];
                            shreg_q    <= shreg_q >> 1;
                            bit_idx_q  <= bit_idx_q + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    serial_out <= parity_q;
                end

                STOP: begin
                    serial_out <= 1'b1;
                    if (stop_left_q == '0) begin
                        busy_out <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        stop_left_q <= stop_left_q - 1'b1;
                        if (stop_left_q == c_STOP_ONE) begin
                            frame_done_out <= 1'b1;
                            sent_count_out <= sent_count_out + 8'd1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase

            // stop_left_q counts cycles remaining after the current stop cycle,
            // so the done pulse lands on the final one.
            if (w_to_stop) begin
                serial_out  <= 1'b1;
                stop_left_q <= c_STOP_LOAD;
                state_q     <= STOP;
                if (c_STOP_TOTAL == 1) begin
                    frame_done_out <= 1'b1;
                    sent_count_out <= sent_count_out + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/serializador.md
Name: serializador

Overview:
Downstream drain stage for the fila queue. Pops one byte at a time from the queue head and transmits it as a framed serial stream: start bit, data bits LSB-first, optional parity, stop bit(s).
Runs entirely in the clk_10KHz domain alongside fila. Completes the byte path deserializer -> fila -> serializer.

Parameters:
DATA_WIDTH, 8, byte width; must equal fila data width.
BIT_CYCLES, 1, clk_10KHz cycles per serial bit (>=1).
PARITY_EN, 0, 1 = insert parity bit after data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0).
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clk_10KHz  input  1  system clock, same as fila.
reset  input  1  asynchronous, active-high.
enable_in  input  1  permits starting a new frame; sampled only in IDLE.
len_in  input  8  fila occupancy (len_out of fila).
data_in  input  DATA_WIDTH  fila head byte; first-word-fall-through, valid whenever len_in != 0.
dequeue_out  output  1  one-cycle pop request to fila.
serial_out  output  1  serial line, idle high.
busy_out  output  1  high from frame launch through last stop bit.
frame_done_out  output  1  one-cycle pulse in the final stop-bit cycle.
sent_count_out  output  8  frames completed, modulo 256.

Behaviour:
- Reset (async): state=IDLE; serial_out=1; dequeue_out=0; busy_out=0; frame_done_out=0; sent_count_out=0; shift reg and bit timer cleared.
- Reset mid-frame: frame is aborted. Line returns high immediately. The already-popped byte is lost; no retransmit.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: if enable_in=1 and len_in!=0 at edge E:
  - capture data_in into shift reg;
  - dequeue_out<=1 for exactly one cycle;
  - serial_out<=0; busy_out<=1; state<=START.
  - Otherwise hold serial_out=1.
- START: hold 0 for BIT_CYCLES cycles, then go to DATA.
- DATA: output shreg[0], shift right every BIT_CYCLES cycles, 8 bits. Then go to PARITY if PARITY_EN, else STOP.
- PARITY: output XOR of captured byte (inverted if PARITY_ODD) for BIT_CYCLES cycles, then go to STOP.
- STOP: output 1 for STOP_BITS*BIT_CYCLES cycles. frame_done_out=1 and sent_count_out increments in the last stop cycle. Then go to IDLE with busy_out<=0.
- Bit timing: internal counter 0..BIT_CYCLES-1. A bit advances when the counter hits BIT_CYCLES-1. The counter resets at each bit boundary.
- Back-to-back period: (1+8+PARITY_EN+STOP_BITS)*BIT_CYCLES + 1 cycles (one IDLE cycle, line high). Defaults give 11.
- dequeue_out is never asserted when len_in==0. It is never asserted outside the IDLE->START edge, so there is at most one pop per frame.
- Simultaneous enqueue by the upstream stage: irrelevant. Only len_in!=0 is checked, and len_in has settled long before the next IDLE.
- enable_in deasserted mid-frame: current frame completes, then the block stays IDLE.
- sent_count_out wraps 255 -> 0.

Decomposition:
- serializador_pkg: typedef enum state_t {IDLE, START, DATA, PARITY, STOP}; constant DATA_BITS=8; function calc_parity(byte, odd).
- Sub-module serializador_bit_timer: BIT_CYCLES counter with clear input and bit_tick output. The FSM, shift register, and counters stay in serializador.

Test Plan:
1. Reset, len_in=0, enable_in=1 for 50 cycles -> serial_out=1, dequeue_out never 1, busy_out=0, sent_count_out=0.
2. len_in=1, data_in=8'hA5, defaults -> single dequeue pulse. Line reads 0,1,0,1,0,0,1,0,1,1 over 10 cycles. frame_done_out pulses once; sent_count_out=1.
3. len_in=3, bytes 8'h01/8'h80/8'hFF -> three frames, each 11 cycles apart. Exactly 3 dequeue pulses; sent_count_out=3.
4. PARITY_EN=1, PARITY_ODD=0, BIT_CYCLES=4, data 8'h07 -> each bit held 4 cycles, parity bit=1. Frame length 44 cycles + 1 idle.
5. Assert reset during DATA bit 3 -> serial_out=1 and busy_out=0 immediately. After release with len_in=0 the block stays IDLE and sent_count_out=0.
6. enable_in dropped during START of a frame with len_in=2 -> frame finishes and no second dequeue. Re-raising enable_in launches the second frame.
